// File: rtl/pc_sequencer.sv
// Single-issue instruction sequencer around the 8-bit ALU: fetch at pc, issue, wait for
// execute completion, then pick the next pc (sequential, relative branch or overflow trap).
module pc_sequencer #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] TRAP_VEC    = 8'hF0,
  parameter bit         OVF_TRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [2:0]  alu_sel,
  input  logic        take_branch,
  input  logic        ovf,
  input  logic [7:0]  br_off,
  output logic [7:0]  pc,
  output logic        trap,
  output logic [7:0]  epc
);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StExec, StUpdate} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  epc_q, epc_d;
  logic [15:0] instr_q, instr_d;
  logic        br_q, br_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  off_q, off_d;
  logic        trap_hit;

  // Only an add (alu_sel 0) overflow traps; the trap outranks any branch decision.
  assign trap_hit = OVF_TRAP_EN && (sel_q == 3'd0) && ovf_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    instr_d = instr_q;
    br_d    = br_q;
    ovf_d   = ovf_q;
    sel_d   = sel_q;
    off_d   = off_q;
    unique case (state_q)
      StIdle: begin
        if (!stall) state_d = StFetch;
      end
      StFetch: begin
        if (imem_valid) begin
          instr_d = imem_data;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StExec;
      end
      StExec: begin
        if (exec_done) begin
          br_d    = take_branch;
          ovf_d   = ovf;
          sel_d   = alu_sel;
          off_d   = br_off;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        if (trap_hit) begin
          epc_d = pc_q;
          pc_d  = TRAP_VEC;
        end else if (br_q) begin
          // 8-bit add of the raw offset is the same as adding its sign extension mod 256.
          pc_d = pc_q + 8'd1 + off_q;
        end else begin
          pc_d = pc_q + 8'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      epc_q   <= 8'h00;
      instr_q <= 16'h0000;
      br_q    <= 1'b0;
      ovf_q   <= 1'b0;
      sel_q   <= 3'd0;
      off_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      instr_q <= instr_d;
      br_q    <= br_d;
      ovf_q   <= ovf_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StIssue);
  assign trap        = (state_q == StUpdate) && trap_hit;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign epc         = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer: one record per instruction plus
// hand-written stall and mid-execute reset sequences.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic [2:0]  alu_sel = 3'd0;
  logic        take_branch = 1'b0;
  logic        ovf = 1'b0;
  logic [7:0]  br_off = 8'h00;
  logic [7:0]  pc;
  logic        trap;
  logic [7:0]  epc;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .alu_sel     (alu_sel),
    .take_branch (take_branch),
    .ovf         (ovf),
    .br_off      (br_off),
    .pc          (pc),
    .trap        (trap),
    .epc         (epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tb;
    logic       ov;
    logic [2:0] sel;
    logic [7:0] off;
    logic [7:0] pc0;
    logic [7:0] pc1;
    logic       trp;
    logic [7:0] epc1;
    int         waits;
    bit         stray;
    bit         stl;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the sequencer is requesting a fetch.
  task automatic wait_fetch(input string name);
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk({name, "_fetch_timeout"}, {31'd0, imem_req}, 32'd1);
  endtask

  task automatic run_instr(input int idx);
    vec_t v = vecs[idx];
    logic [15:0] data;
    data = {8'hA5 ^ 8'(idx), v.pc0};
    wait_fetch($sformatf("v%0d", idx));
    for (int w = 0; w <= v.waits; w++) begin
      chk($sformatf("v%0d_req_w%0d", idx, w), {31'd0, imem_req}, 32'd1);
      chk($sformatf("v%0d_addr_w%0d", idx, w), {24'd0, imem_addr}, {24'd0, v.pc0});
      imem_valid = (w == v.waits);
      imem_data  = (w == v.waits) ? data : 16'hDEAD;
      exec_done  = v.stray && (w < v.waits);
      take_branch = 1'b1;
      ovf         = 1'b1;
      step();
    end
    imem_valid = 1'b0;
    exec_done  = 1'b0;
    chk($sformatf("v%0d_issue", idx), {31'd0, instr_valid}, 32'd1);
    chk($sformatf("v%0d_instr", idx), {16'd0, instr}, {16'd0, data});
    step();
    chk($sformatf("v%0d_issue_off", idx), {31'd0, instr_valid}, 32'd0);
    exec_done   = 1'b1;
    take_branch = v.tb;
    ovf         = v.ov;
    alu_sel     = v.sel;
    br_off      = v.off;
    step();
    // Scramble the ALU inputs during UPDATE: only the sampled values may matter.
    exec_done   = 1'b0;
    take_branch = ~v.tb;
    ovf         = ~v.ov;
    alu_sel     = ~v.sel;
    br_off      = ~v.off;
    chk($sformatf("v%0d_trap", idx), {31'd0, trap}, {31'd0, v.trp});
    if (v.stl) stall = 1'b1;
    step();
    take_branch = 1'b0;
    ovf         = 1'b0;
    chk($sformatf("v%0d_trap_off", idx), {31'd0, trap}, 32'd0);
    chk($sformatf("v%0d_pc", idx), {24'd0, pc}, {24'd0, v.pc1});
    chk($sformatf("v%0d_epc", idx), {24'd0, epc}, {24'd0, v.epc1});
    chk($sformatf("v%0d_idle", idx), {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           tb    ov    sel   off    pc0    pc1    trp   epc   w  stray stall
    vecs[0]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd1, 8'h0E, 8'h01, 8'h10, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'd1, 8'hFC, 8'h10, 8'h0D, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'd1, 8'h05, 8'h0D, 8'h13, 1'b0, 8'h00, 3, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'd3, 8'h0C, 8'h13, 8'h20, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 3'd0, 8'h05, 8'h20, 8'hF0, 1'b1, 8'h20, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'd2, 8'h00, 8'hF0, 8'hF1, 1'b0, 8'h20, 0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'd1, 8'h2E, 8'hF1, 8'h20, 1'b0, 8'h20, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'd2, 8'h00, 8'h20, 8'h21, 1'b0, 8'h20, 0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'd1, 8'hDD, 8'h21, 8'hFF, 1'b0, 8'h20, 0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h20, 0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3'd1, 8'hFD, 8'h00, 8'hFE, 1'b0, 8'h20, 0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'd1, 8'h05, 8'hFE, 8'h04, 1'b0, 8'h20, 0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 3'd1, 8'h10, 8'h04, 8'h15, 1'b0, 8'h20, 1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h15, 8'h16, 1'b0, 8'h20, 0, 1'b0, 1'b0};

    // Reset state.
    #12;
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'h0);
    chk("rst_epc", {24'd0, epc}, 32'h00);
    rst_n = 1'b1;
    #1;
    chk("idle_after_rst", {31'd0, imem_req}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_instr(i);
      if (vecs[i].stl) begin
        for (int c = 0; c < 4; c++) begin
          step();
          chk($sformatf("stall_req_c%0d", c), {31'd0, imem_req}, 32'd0);
          chk($sformatf("stall_pc_c%0d", c), {24'd0, pc}, {24'd0, vecs[i].pc1});
        end
        stall = 1'b0;
        step();
        chk("stall_release_fetch", {31'd0, imem_req}, 32'd1);
      end
    end

    // Reset mid-execute, with exec_done held across release.
    wait_fetch("rstx");
    imem_valid = 1'b1;
    imem_data  = 16'h1234;
    step();
    imem_valid = 1'b0;
    step();
    exec_done = 1'b1;
    take_branch = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstx_pc", {24'd0, pc}, 32'h00);
    chk("rstx_instr", {16'd0, instr}, 32'h0);
    chk("rstx_epc", {24'd0, epc}, 32'h00);
    chk("rstx_req", {31'd0, imem_req}, 32'd0);
    chk("rstx_ivalid", {31'd0, instr_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rstx_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("rstx_fetch_addr", {24'd0, imem_addr}, 32'h00);
    step();
    chk("rstx_hold_req", {31'd0, imem_req}, 32'd1);
    chk("rstx_hold_pc", {24'd0, pc}, 32'h00);
    exec_done = 1'b0;
    take_branch = 1'b0;
    vecs[0].epc1 = 8'h00;
    run_instr(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-sequencing stage directly around the 8-bit ALU.
- Fetches each instruction from instruction memory at the current PC, issues it to decode/ALU, then waits for execute completion.
- Consumes the ALU's take_branch and ovf outputs to choose the next PC: sequential, relative branch, or overflow trap.
- Single-issue, multi-cycle; no pipelining.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- TRAP_VEC, 8'hF0, PC loaded on an add-overflow trap.
- OVF_TRAP_EN, 1, 1 = add overflow traps; 0 = ovf ignored.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  holds the sequencer before the next fetch request
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  8  fetch address, equals pc while imem_req=1
- imem_valid  in  1  instruction memory data valid
- imem_data  in  16  fetched instruction word
- instr  out  16  latched instruction presented to decode/ALU
- instr_valid  out  1  one-cycle issue pulse
- exec_done  in  1  ALU result/branch/ovf stable this cycle
- alu_sel  in  3  ALU op select of the executing instruction
- take_branch  in  1  ALU branch decision
- ovf  in  1  ALU overflow
- br_off  in  8  signed branch offset from the decoded instruction
- pc  out  8  current PC
- trap  out  1  one-cycle trap pulse
- epc  out  8  PC of the trapping instruction

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, pc=RESET_PC.
  - instr=0, epc=0.
  - imem_req, instr_valid, trap all 0.
  - Reset takes effect immediately, including mid-fetch or mid-execute. Any pending imem or exec response is discarded.
- States: IDLE, FETCH, ISSUE, EXEC, UPDATE.
- IDLE:
  - stall=0 -> FETCH next cycle.
  - stall=1 -> stay in IDLE.
  - After reset, IDLE lasts at least one cycle.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_valid.
  - imem_valid=1 -> instr<=imem_data, go to ISSUE.
  - Zero-wait memory: imem_valid in the first FETCH cycle is accepted.
- ISSUE:
  - instr_valid=1 for exactly one cycle, then EXEC.
- EXEC:
  - Wait for exec_done.
  - On exec_done=1, sample take_branch, ovf, alu_sel and br_off, then go to UPDATE.
- UPDATE (one cycle), next-PC priority:
  1. Trap: OVF_TRAP_EN=1, alu_sel==3'd0 and ovf=1 -> epc<=pc, pc<=TRAP_VEC, trap=1 this cycle.
  2. Branch: take_branch=1 -> pc<=pc+1+sext(br_off).
  3. Otherwise pc<=pc+1.
  - Then IDLE (stall is honoured there).
- Arithmetic:
  - All PC arithmetic is 8-bit modulo 256: 8'hFF+1 = 8'h00.
  - Branch target wraps in both directions.
  - br_off is two's complement, range -128..+127.
- Ignored inputs:
  - imem_valid outside FETCH is ignored.
  - exec_done outside EXEC is ignored.
  - take_branch and ovf are only sampled together with exec_done.
- Simultaneous ovf=1 and take_branch=1: trap wins; branch discarded.
- ovf with alu_sel!=0 never traps.
- stall asserted during FETCH/ISSUE/EXEC/UPDATE has no effect until the state returns to IDLE.
- Trap from TRAP_VEC code is permitted: epc is overwritten, no nesting state.
- Issue latency, zero-wait memory and no stall:
  - IDLE→FETCH→ISSUE→EXEC→UPDATE.
  - Minimum 5 cycles per instruction with exec_done in the first EXEC cycle.

Test Plan:
- Reset with RESET_PC=8'h00, release rst_n, stall=0, 0-wait imem -> imem_addr=8'h00 on the first FETCH cycle; instr_valid pulses once; after exec_done with no branch, pc=8'h01.
- pc=8'h10, take_branch=1, br_off=8'hFC -> pc=8'h0D. Then br_off=8'h05, take_branch=1 -> pc=8'h13.
- pc=8'h20, alu_sel=0, ovf=1, take_branch=1 -> trap pulse 1 cycle, epc=8'h20, pc=8'hF0. Repeat with alu_sel=3'd2, ovf=1 -> no trap, pc=8'h21.
- Wrap: pc=8'hFF, no branch -> pc=8'h00. pc=8'hFE, br_off=8'h05 -> pc=8'h04.
- stall=1 held 4 cycles after UPDATE -> imem_req stays 0 and pc unchanged; stall=0 -> FETCH next cycle. Memory with 3 wait states -> imem_req and imem_addr stable all 3 cycles; stray exec_done during FETCH ignored.
- rst_n dropped in EXEC -> outputs zero immediately and pc=RESET_PC; exec_done arriving after release is ignored; sequencer restarts at IDLE.
